axi_mem_master: RTL and testbench

AXI_MEM_MASTER -- requirements
Module: axi_mem_master

---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_mem_master.sv | 208 ++++++++++++++++++++
 tb/tb_axi_mem_master.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared AXI4 burst/response encodings and attribute defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_pkg;

   localparam logic [1:0] c_burst_fixed = 2'b00;
   localparam logic [1:0] c_burst_incr  = 2'b01;
   localparam logic [1:0] c_burst_wrap  = 2'b10;

   localparam logic [1:0] c_resp_okay   = 2'b00;
   localparam logic [1:0] c_resp_exokay = 2'b01;
   localparam logic [1:0] c_resp_slverr = 2'b10;
   localparam logic [1:0] c_resp_decerr = 2'b11;

   // Normal non-cacheable bufferable, unprivileged secure data access.
   localparam logic [3:0] c_cache_default = 4'b0011;
   localparam logic [2:0] c_prot_default  = 3'b000;

endpackage

`default_nettype wire

// File: rtl/axi_mem_master.sv
// ============================================================================
//  Module      : axi_mem_master
//  Description : Single-outstanding AXI4 burst master bridging a command port
//                and beat streams onto AXI4 read/write channels.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_mem_master
   import axi_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8,
   parameter int MASTER_ID  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [7:0]            req_len,
   input  logic [2:0]            req_size,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [STRB_WIDTH-1:0] wr_strb,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic                  done,
   output logic                  err,
   output logic [ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awlock,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_WIDTH-1:0] m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [ID_WIDTH-1:0]   m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam int c_max_size = $clog2(STRB_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_AW    = 3'd1,
      S_WDATA = 3'd2,
      S_BRESP = 3'd3,
      S_AR    = 3'd4,
      S_RDATA = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_len;
   logic [7:0]            r_beat;
   logic [2:0]            r_size;
   logic                  r_sticky;
   logic                  r_done;
   logic                  r_err;

   logic                  w_accept;
   logic                  w_w_hs;
   logic                  w_b_hs;
   logic                  w_r_hs;
   logic                  w_r_end;
   logic                  w_last_beat;
   logic                  w_rresp_bad;
   logic [2:0]            w_size_clamped;
   logic                  w_unused_ids;

   // Transaction IDs are not checked: only one burst is ever outstanding.
   assign w_unused_ids   = ^{m_axi_bid, m_axi_rid};

   assign w_size_clamped = (req_size > 3'(c_max_size)) ? 3'(c_max_size) : req_size;
   assign w_accept       = req_valid && req_ready;
   assign w_last_beat    = (r_beat == r_len);
   assign w_w_hs         = m_axi_wvalid && m_axi_wready;
   assign w_b_hs         = (r_state == S_BRESP) && m_axi_bvalid;
   assign w_r_hs         = m_axi_rvalid && m_axi_rready;
   assign w_rresp_bad    = (m_axi_rresp != c_resp_okay);
   // A slave that never raises rlast is cut off at the expected final beat.
   assign w_r_end        = m_axi_rlast || w_last_beat;

   assign req_ready      = (r_state == S_IDLE);
   assign done           = r_done;
   assign err            = r_err;

   assign m_axi_awid     = ID_WIDTH'(MASTER_ID);
   assign m_axi_awaddr   = r_addr;
   assign m_axi_awlen    = r_len;
   assign m_axi_awsize   = r_size;
   assign m_axi_awburst  = c_burst_incr;
   assign m_axi_awlock   = 1'b0;
   assign m_axi_awcache  = c_cache_default;
   assign m_axi_awprot   = c_prot_default;
   assign m_axi_awvalid  = (r_state == S_AW);

   assign m_axi_wdata    = wr_data;
   assign m_axi_wstrb    = wr_strb;
   assign m_axi_wlast    = w_last_beat;
   assign m_axi_wvalid   = (r_state == S_WDATA) && wr_valid;
   assign wr_ready       = (r_state == S_WDATA) && m_axi_wready;
   assign m_axi_bready   = (r_state == S_BRESP);

   assign m_axi_arid     = ID_WIDTH'(MASTER_ID);
   assign m_axi_araddr   = r_addr;
   assign m_axi_arlen    = r_len;
   assign m_axi_arsize   = r_size;
   assign m_axi_arburst  = c_burst_incr;
   assign m_axi_arlock   = 1'b0;
   assign m_axi_arcache  = c_cache_default;
   assign m_axi_arprot   = c_prot_default;
   assign m_axi_arvalid  = (r_state == S_AR);

   assign rd_data        = m_axi_rdata;
   assign rd_last        = m_axi_rlast;
   assign rd_valid       = (r_state == S_RDATA) && m_axi_rvalid;
   assign m_axi_rready   = (r_state == S_RDATA) && rd_ready;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req_valid) w_next = req_write ? S_AW : S_AR;
         S_AW:    if (m_axi_awready) w_next = S_WDATA;
         S_WDATA: if (w_w_hs && w_last_beat) w_next = S_BRESP;
         S_BRESP: if (m_axi_bvalid) w_next = S_IDLE;
         S_AR:    if (m_axi_arready) w_next = S_RDATA;
         S_RDATA: if (w_r_hs && w_r_end) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr   <= '0;
         r_len    <= '0;
         r_size   <= '0;
         r_beat   <= '0;
         r_sticky <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (w_accept) begin
            r_addr   <= req_addr;
            r_len    <= req_len;
            r_size   <= w_size_clamped;
            r_beat   <= '0;
            r_sticky <= 1'b0;
         end
         if (w_w_hs && !w_last_beat) r_beat <= r_beat + 8'd1;
         if (w_b_hs) begin
            r_done <= 1'b1;
            r_err  <= (m_axi_bresp != c_resp_okay) || r_sticky;
         end
         if (w_r_hs) begin
            if (!w_last_beat) r_beat <= r_beat + 8'd1;
            if (w_rresp_bad) r_sticky <= 1'b1;
            if (w_r_end) begin
               r_done <= 1'b1;
               r_err  <= r_sticky || w_rresp_bad || !m_axi_rlast;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_master.sv
// ============================================================================
//  Module      : tb_axi_mem_master
//  Description : Self-checking bench for axi_mem_master with a behavioural
//                AXI memory slave and a word-level reference memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_mem_master;
   import axi_pkg::*;

   localparam int c_mid = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [15:0] req_addr = '0;
   logic [7:0]  req_len = '0;
   logic [2:0]  req_size = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_strb = '0;
   logic        wr_valid = 1'b0, wr_ready;
   logic [31:0] rd_data;
   logic        rd_last, rd_valid, rd_ready = 1'b1;
   logic        done, err;
   logic [7:0]  awid, arid, bid, rid;
   logic [15:0] awaddr, araddr;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize, awprot, arprot;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awlock, arlock;
   logic [3:0]  awcache, arcache, wstrb;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [31:0] wdata, rdata;

   always #5 clk = ~clk;

   axi_mem_master #(
      .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8), .MASTER_ID(c_mid)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done(done), .err(err),
      .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
      .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
      .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
      .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
      .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   // Behavioural AXI memory slave, one burst at a time
   bit   [31:0] ram [0:16383];
   logic        aw_block = 1'b0, no_rlast = 1'b0;
   logic [1:0]  force_bresp = 2'b00, force_rresp = 2'b00;
   logic        s_w_act, s_bvalid, s_r_act, wlast_bad;
   logic [15:0] s_waddr, s_raddr;
   logic [7:0]  s_wlen, s_wcnt, s_rlen, s_rcnt;
   logic [1:0]  s_bresp;
   logic [31:0] w_merged;

   assign awready = !aw_block;
   assign wready  = s_w_act;
   assign bvalid  = s_bvalid;
   assign bresp   = s_bresp;
   assign bid     = 8'hA5;
   assign arready = 1'b1;
   assign rvalid  = s_r_act;
   assign rdata   = ram[s_raddr[15:2]];
   assign rresp   = force_rresp;
   assign rlast   = s_r_act && (s_rcnt == s_rlen) && !no_rlast;
   assign rid     = 8'h3C;

   always_comb begin
      w_merged = ram[s_waddr[15:2]];
      for (int b = 0; b < 4; b++)
         if (wstrb[b]) w_merged[8*b +: 8] = wdata[8*b +: 8];
   end

   always @(posedge clk) begin
      if (rst) begin
         s_w_act  <= 1'b0;
         s_bvalid <= 1'b0;
         s_r_act  <= 1'b0;
      end else begin
         if (awvalid && awready) begin
            s_w_act <= 1'b1; s_waddr <= awaddr; s_wlen <= awlen; s_wcnt <= 8'd0;
         end
         if (wvalid && wready) begin
            ram[s_waddr[15:2]] <= w_merged;
            s_waddr <= s_waddr + 16'd4;
            s_wcnt  <= s_wcnt + 8'd1;
            if (wlast !== (s_wcnt == s_wlen)) wlast_bad <= 1'b1;
            if (wlast) begin
               s_w_act <= 1'b0; s_bvalid <= 1'b1; s_bresp <= force_bresp;
            end
         end
         if (bvalid && bready) s_bvalid <= 1'b0;
         if (arvalid && arready) begin
            s_r_act <= 1'b1; s_raddr <= araddr; s_rlen <= arlen; s_rcnt <= 8'd0;
         end
         if (rvalid && rready) begin
            s_raddr <= s_raddr + 16'd4;
            s_rcnt  <= s_rcnt + 8'd1;
            if (s_rcnt == s_rlen) s_r_act <= 1'b0;
         end
      end
   end

   // Bus monitor
   int          cyc = 0, hs_cyc = 0, done_cnt = 0;
   logic [31:0] rd_q[$];
   logic        rdl_q[$];
   logic [15:0] cap_awaddr, cap_araddr;
   logic [7:0]  cap_awlen, cap_awid, cap_arid;
   logic [2:0]  cap_awsize, cap_arsize;
   logic [1:0]  cap_awburst, cap_arburst;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
      if ((bvalid && bready) || (rvalid && rready && s_rcnt == s_rlen)) hs_cyc <= cyc;
      if (rd_valid && rd_ready) begin
         rd_q.push_back(rd_data);
         rdl_q.push_back(rd_last);
      end
      if (awvalid && awready) begin
         cap_awaddr <= awaddr; cap_awlen <= awlen; cap_awsize <= awsize;
         cap_awburst <= awburst; cap_awid <= awid;
      end
      if (arvalid && arready) begin
         cap_araddr <= araddr; cap_arsize <= arsize; cap_arburst <= arburst; cap_arid <= arid;
      end
   end

   // Reference model: word-addressed memory image
   int          passed = 0, total = 0;
   logic [31:0] model_mem [int];

   function automatic logic [31:0] mread(input int idx);
      return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic model_write(input logic [15:0] a, input logic [31:0] d[$], input logic [3:0] s[$]);
      for (int i = 0; i < d.size(); i++) begin
         int          idx;
         logic [31:0] w, dt;
         logic [3:0]  st;
         idx = int'(a >> 2) + i;
         w   = mread(idx);
         dt  = d[i];
         st  = s[i];
         for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = dt[8*b +: 8];
         model_mem[idx] = w;
      end
   endtask

   task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] l, input logic [2:0] sz);
      int n = 0;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l; req_size = sz;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("req_accept", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic send_beats(input int nb, input logic [31:0] d[$], input logic [3:0] s[$]);
      for (int i = 0; i < nb; i++) begin
         int n = 0;
         wr_valid = 1'b1; wr_data = d[i]; wr_strb = s[i];
         while (!wr_ready && n < 100) begin @(negedge clk); n++; end
         if (n >= 100) check("wr_beat_accept", wr_ready, 1);
         @(negedge clk);
      end
      wr_valid = 1'b0;
   endtask

   // Returns at the negedge where done is high, so the caller can go back-to-back
   task automatic wait_done(input bit tog, input string tag, output logic e);
      int n = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         if (tog) rd_ready = ~rd_ready;
         n++;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_ready_with_done"}, req_ready, 1);
      check({tag, "_done_latency"}, 64'(cyc - hs_cyc), 1);
      e = err;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [31:0] d[$], input logic [3:0] s[$],
                           input logic [1:0] br, input logic exp_err, input string tag);
      logic e;
      force_bresp = br;
      issue(1'b1, a, 8'(d.size() - 1), 3'd2);
      send_beats(d.size(), d, s);
      wait_done(1'b0, tag, e);
      check({tag, "_err"}, e, exp_err);
      check({tag, "_awaddr"}, cap_awaddr, a);
      check({tag, "_awlen"}, cap_awlen, d.size() - 1);
      check({tag, "_aw_attr"}, {cap_awid, cap_awsize, cap_awburst}, {8'(c_mid), 3'd2, c_burst_incr});
      check({tag, "_wlast_pos"}, wlast_bad, 0);
      model_write(a, d, s);
      force_bresp = 2'b00;
   endtask

   task automatic do_read(input logic [15:0] a, input logic [7:0] l, input logic [2:0] sz,
                          input bit tog, input logic exp_err, input string tag);
      logic e;
      rd_q.delete();
      rdl_q.delete();
      issue(1'b0, a, l, sz);
      wait_done(tog, tag, e);
      rd_ready = 1'b1;
      check({tag, "_err"}, e, exp_err);
      check({tag, "_beats"}, rd_q.size(), int'(l) + 1);
      for (int i = 0; i <= int'(l) && i < rd_q.size(); i++) begin
         check($sformatf("%s_data%0d", tag, i), rd_q[i], mread(int'(a >> 2) + i));
         check($sformatf("%s_last%0d", tag, i), rdl_q[i], (i == int'(l)) && !no_rlast);
      end
      check({tag, "_araddr"}, cap_araddr, a);
      check({tag, "_arsize"}, cap_arsize, (sz > 3'd2) ? 3'd2 : sz);
   endtask

   initial begin
      logic [31:0] d[$];
      logic [3:0]  s[$];
      logic [15:0] a;
      logic [7:0]  l;
      int          d0;

      wlast_bad = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_valids", {awvalid, arvalid, done, err}, 4'b0000);
      check("const_attrs", {awlock, awcache, awprot, arlock, arcache, arprot},
            {1'b0, c_cache_default, c_prot_default, 1'b0, c_cache_default, c_prot_default});

      // Single-beat write
      d = '{32'hDEADBEEF}; s = '{4'hF};
      do_write(16'h0010, d, s, 2'b00, 1'b0, "single_wr");
      @(negedge clk);
      check("single_wr_ram4", ram[4], 32'hDEADBEEF);

      // 4-beat write then read back, two completion pulses
      d0 = done_cnt;
      d = '{32'd1, 32'd2, 32'd3, 32'd4}; s = '{4'hF, 4'hF, 4'hF, 4'hF};
      do_write(16'h0100, d, s, 2'b00, 1'b0, "burst4_wr");
      do_read(16'h0100, 8'd3, 3'd2, 1'b0, 1'b0, "burst4_rd");
      @(negedge clk);
      check("burst4_done_pulses", done_cnt - d0, 2);
      check("done_one_cycle", done, 0);

      // 8-beat read with rd_ready throttled every other cycle
      d.delete(); s.delete();
      for (int i = 0; i < 8; i++) begin d.push_back($urandom); s.push_back(4'hF); end
      do_write(16'h0200, d, s, 2'b00, 1'b0, "len7_wr");
      do_read(16'h0200, 8'd7, 3'd2, 1'b1, 1'b0, "len7_tog_rd");

      // Error responses and recovery
      d = '{32'h1111_2222}; s = '{4'hF};
      do_write(16'h0300, d, s, 2'b10, 1'b1, "bresp_err_wr");
      d = '{32'h3333_4444}; s = '{4'hF};
      do_write(16'h0304, d, s, 2'b00, 1'b0, "clean_wr");
      force_rresp = 2'b10;
      do_read(16'h0200, 8'd2, 3'd2, 1'b0, 1'b1, "rresp_err_rd");
      force_rresp = 2'b00;
      no_rlast = 1'b1;
      do_read(16'h0200, 8'd3, 3'd2, 1'b0, 1'b1, "no_rlast_rd");
      no_rlast = 1'b0;
      do_read(16'h0100, 8'd1, 3'd7, 1'b0, 1'b0, "clamp_rd");

      // AW stall: address phase must hold stable
      aw_block = 1'b1;
      issue(1'b1, 16'h0400, 8'd1, 3'd2);
      for (int i = 0; i < 5; i++) begin
         check("aw_stall_hold", {awvalid, awaddr, awlen}, {1'b1, 16'h0400, 8'd1});
         @(negedge clk);
      end
      aw_block = 1'b0;
      d = '{32'hCAFE_0001, 32'hCAFE_0002}; s = '{4'hF, 4'hF};
      send_beats(2, d, s);
      begin
         logic e;
         wait_done(1'b0, "aw_stall", e);
         check("aw_stall_err", e, 0);
      end
      model_write(16'h0400, d, s);

      // Randomised full write, partial-strobe overwrite, read back
      for (int t = 0; t < 6; t++) begin
         a = 16'(32'h1000 + $urandom_range(0, 511) * 64);
         l = 8'($urandom_range(0, 15));
         d.delete(); s.delete();
         for (int i = 0; i <= int'(l); i++) begin d.push_back($urandom); s.push_back(4'hF); end
         do_write(a, d, s, 2'b00, 1'b0, $sformatf("rnd%0d_wr", t));
         d.delete(); s.delete();
         for (int i = 0; i <= int'(l); i++) begin d.push_back($urandom); s.push_back(4'($urandom)); end
         do_write(a, d, s, 2'b00, 1'b0, $sformatf("rnd%0d_strb_wr", t));
         do_read(a, l, 3'd2, t[0], 1'b0, $sformatf("rnd%0d_rd", t));
      end

      // Reset in the middle of a write burst
      @(negedge clk);
      d0 = done_cnt;
      d = '{32'hA0, 32'hA1}; s = '{4'hF, 4'hF};
      issue(1'b1, 16'h0800, 8'd3, 3'd2);
      send_beats(2, d, s);
      wr_valid = 1'b1; wr_data = 32'hA2; wr_strb = 4'hF;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wr_valid = 1'b0;
      check("midrst_valids", {awvalid, arvalid, done}, 3'b000);
      check("midrst_req_ready", req_ready, 1);
      repeat (5) @(negedge clk);
      check("midrst_no_done", done_cnt - d0, 0);
      model_write(16'h0800, d, s);
      d = '{32'h5A5A_0000, 32'h5A5A_0001}; s = '{4'hF, 4'hF};
      do_write(16'h0900, d, s, 2'b00, 1'b0, "post_rst_wr");
      do_read(16'h0900, 8'd1, 3'd2, 1'b0, 1'b0, "post_rst_rd");

      @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $error("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
